// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over four requesters with a bounded hold time per grant.
// The registered grant index drives a 4:1 mux of the channel data buses.
module rr_mux_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  input  logic [1:0] d,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic [1:0] y,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [3:0] hold_q,  hold_d;
  logic [3:0] gnt_q,   gnt_d;
  logic [1:0] sel_q,   sel_d;
  logic       busy_q,  busy_d;

  logic [2:0] win_home;
  logic [2:0] win_next;
  logic [1:0] next_ptr;
  logic       grant_end;

  // Returns {found, index} of the first requester at or after base, modulo 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign next_ptr  = sel_q + 2'd1;
  assign win_home  = pick(req, ptr_q);
  assign win_next  = pick(req, next_ptr);
  assign grant_end = !req[sel_q] || (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (win_home[2]) begin
          state_d = GRANT;
          sel_d   = win_home[1:0];
          gnt_d   = onehot(win_home[1:0]);
          busy_d  = 1'b1;
          hold_d  = 4'd0;
        end
      end
      GRANT: begin
        if (grant_end) begin
          // Ending grant rotates priority and re-arbitrates in the same edge.
          ptr_d  = next_ptr;
          hold_d = 4'd0;
          if (win_next[2]) begin
            sel_d = win_next[1:0];
            gnt_d = onehot(win_next[1:0]);
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      hold_q  <= 4'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    y = 2'b00;
    if (gnt_q != 4'b0000) begin
      case (sel_q)
        2'd0:    y = a;
        2'd1:    y = b;
        2'd2:    y = c;
        default: y = d;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 4: maximum consecutive cycles one requester holds the grant; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous to clk and active-high.
REQ-004 req  input  4  request per channel; bit i = channel i.
REQ-005 a, b, c, d  input  2 each  channel data for channels 0..3 respectively.
REQ-006 gnt  output  4  one-hot grant; registered; all-zero when no channel is granted.
REQ-007 sel  output  2  index of the granted channel; registered; drives the 4:1 data select.
REQ-008 y  output  2  selected data; combinational from sel: 0->a, 1->b, 2->c, 3->d; forced to 2'b00 when gnt is zero.
REQ-009 busy  output  1  registered; high while in GRANT state.

Function
REQ-010 The block SHALL have two states: IDLE (gnt=0) and GRANT (exactly one gnt bit high).
REQ-011 The block SHALL keep a 2-bit priority pointer ptr. Search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
REQ-012 In IDLE with any req bit high at edge N, the block SHALL enter GRANT at edge N with the first requesting channel in search order; gnt, sel and busy update at that edge (1-cycle latency from req to gnt).
REQ-013 In IDLE with req=0, the block SHALL stay in IDLE; sel holds its last value.
REQ-014 In GRANT, a 4-bit hold counter SHALL count granted cycles, starting at 0 on each new grant.
REQ-015 A grant SHALL end at an edge where either of these holds: the granted channel's req bit is low, or the hold counter equals HOLD_MAX-1.
REQ-016 When a grant to channel k ends, ptr SHALL become (k+1) mod 4. Channel 3 wraps to 0.
REQ-017 At the same edge a grant ends, the block SHALL re-arbitrate among the current req bits using the new ptr:
  - If any channel is requesting, it SHALL grant the winner directly, with no idle cycle.
  - Otherwise it SHALL go to IDLE.
REQ-018 If HOLD_MAX expires while channel k is the only requester, channel k SHALL be re-granted with its hold counter reset to 0.
REQ-019 Changes to req bits of non-granted channels during GRANT SHALL NOT affect gnt until the current grant ends.
REQ-020 ptr SHALL change only when a grant ends, never on the initial grant from IDLE.
REQ-021 gnt SHALL never have more than one bit set. When gnt is nonzero, sel SHALL equal the index of the set bit.
REQ-022 With HOLD_MAX=1, every grant SHALL last exactly one cycle, which gives pure round-robin rotation.

Reset
REQ-023 While rst=1 at an edge, the block SHALL go to IDLE, regardless of current state or req.
REQ-024 That edge SHALL also force gnt=4'b0000, sel=2'b00, busy=0, ptr=0 and hold counter=0.
REQ-025 Reset asserted mid-grant SHALL drop the grant at that edge with no ptr update. After rst falls, arbitration resumes from ptr=0 per REQ-012.

Verification
REQ-026 Reset then idle: rst=1 for 2 cycles, req=0 -> gnt=0000, sel=00, busy=0, y=00 throughout.
REQ-027 Single request: req=0100 from cycle 1, c=2'b10, HOLD_MAX=4 ->
  - gnt=0100, sel=10, y=10 from the next edge;
  - re-granted every 4 cycles with no gap;
  - ptr=3 after the first expiry.
REQ-028 All request, HOLD_MAX=1: req=1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001, ... one cycle each, with y following a, b, c, d.
REQ-029 Early release with overlap:
  - ch0 granted;
  - req drops to 0110 two cycles later -> gnt=0010 at that edge with no idle cycle;
  - drop req[1] -> gnt=0100.
REQ-030 Mid-grant reset: ch2 granted with hold counter=2, rst=1 for one cycle -> gnt=0000, ptr=0. With req=1100 held afterward -> gnt=0100 one edge after rst falls.
REQ-031 Late request ignored: ch1 granted; req[0] rises mid-grant -> gnt stays 0010 until ch1 releases, then ch0 waits behind ch2/ch3 per ptr=2 order.
